// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch-control bus between the core control path (master) and pc_fetch_unit (slave)
interface pc_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        last_instr_flag;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic        fault;
    logic [31:0] retired_count;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target, last_instr_flag,
        input  pc, pc_plus4, halted, fault, retired_count
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target, last_instr_flag,
        output pc, pc_plus4, halted, fault, retired_count
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and next-PC select with halt/fault freeze; PC_PERF_EN enables retired_count
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    pc_fetch_unit_if.slave   bus
);
    // HALT and FAULT each own one state bit so halted/fault come straight off a flop.
    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_HALT  = 2'b01,
        S_FAULT = 2'b10
    } state_t;

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        target_illegal;

    assign pc_plus4        = pc_q + 32'd4;
    assign redirect        = bus.jump | bus.branch_taken;
    assign redirect_target = bus.jump ? bus.jump_target : bus.branch_target;
    assign target_illegal  = (redirect_target[1:0] != 2'b00) || (redirect_target >= IMEM_LIMIT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_RUN: begin
                if (bus.last_instr_flag) begin
                    state_d = S_HALT;
                end else if (bus.stall) begin
                    pc_d = pc_q;
                end else if (redirect) begin
                    if (target_illegal) state_d = S_FAULT;
                    else                pc_d    = redirect_target;
                end else if (pc_plus4 >= IMEM_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_PERF_EN
    logic [31:0] count_q, count_d;
    logic        advance;

    // PC loads whenever RUN is kept without end-of-program or stall.
    assign advance = (state_q == S_RUN) && (state_d == S_RUN) &&
                     !bus.last_instr_flag && !bus.stall;

    always_comb begin
        count_d = count_q;
        if (advance && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= 32'd0;
        else        count_q <= count_d;
    end

    assign bus.retired_count = count_q;
`else
    assign bus.retired_count = 32'd0;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.halted   = state_q[0];
    assign bus.fault    = state_q[1];
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(128)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef PC_PERF_EN
        return 32'(n);
`else
        return 32'd0 + 32'(n * 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic h, input logic f, input int cnt);
        check({tag, ".pc"}, bus.pc, pc);
        check({tag, ".pc_plus4"}, bus.pc_plus4, pc + 32'd4);
        check({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, h});
        check({tag, ".fault"}, {31'd0, bus.fault}, {31'd0, f});
        check({tag, ".count"}, bus.retired_count, cnt_exp(cnt));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
        bus.last_instr_flag = 1'b0; bus.branch_target = 32'h0; bus.jump_target = 32'h0;
    endtask

    // Pulse reset between edges and confirm the asynchronous clear.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_state(tag, 32'h0, 1'b0, 1'b0, 0);
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        tick();
        check_state("reset", 32'h0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check_state($sformatf("seq%0d", i), 32'(4 * i), 1'b0, 1'b0, i);
        end

        // jump beats branch when both are asserted
        bus.branch_taken = 1'b1; bus.branch_target = 32'h40;
        bus.jump = 1'b1; bus.jump_target = 32'h20;
        tick(); clear_inputs();
        check_state("jump_wins", 32'h20, 1'b0, 1'b0, 5);

        bus.branch_taken = 1'b1; bus.branch_target = 32'h08;
        tick(); clear_inputs();
        check_state("branch", 32'h08, 1'b0, 1'b0, 6);

        bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h40;
        tick();
        check_state("stall_redirect", 32'h08, 1'b0, 1'b0, 6);
        bus.stall = 1'b0;
        tick(); clear_inputs();
        check_state("held_redirect", 32'h40, 1'b0, 1'b0, 7);

        bus.branch_taken = 1'b1; bus.branch_target = 32'h10;
        tick(); clear_inputs();
        check_state("branch_back", 32'h10, 1'b0, 1'b0, 8);

        bus.jump = 1'b1; bus.jump_target = 32'h22;
        tick(); clear_inputs();
        check_state("misaligned_jump", 32'h10, 1'b0, 1'b1, 8);
        bus.last_instr_flag = 1'b1; bus.jump = 1'b1; bus.jump_target = 32'h30;
        tick(); tick(); clear_inputs();
        check_state("fault_sticky", 32'h10, 1'b0, 1'b1, 8);

        reset_pulse("rst_from_fault");
        check_state("post_rst_fault", 32'h4, 1'b0, 1'b0, 1);

        bus.branch_taken = 1'b1; bus.branch_target = 32'h18;
        tick(); clear_inputs();
        check_state("to_0x18", 32'h18, 1'b0, 1'b0, 2);
        bus.last_instr_flag = 1'b1; bus.stall = 1'b1;
        tick(); clear_inputs();
        check_state("halt", 32'h18, 1'b1, 1'b0, 2);
        bus.jump = 1'b1; bus.jump_target = 32'h0;
        tick(); clear_inputs();
        check_state("halt_sticky", 32'h18, 1'b1, 1'b0, 2);

        reset_pulse("rst_from_halt");
        check_state("post_rst_halt", 32'h4, 1'b0, 1'b0, 1);

        bus.branch_taken = 1'b1; bus.branch_target = 32'h80;
        tick(); clear_inputs();
        check_state("range_branch", 32'h4, 1'b0, 1'b1, 1);

        reset_pulse("rst_again");
        bus.jump = 1'b1; bus.jump_target = 32'h78;
        tick(); clear_inputs();
        check_state("to_0x78", 32'h78, 1'b0, 1'b0, 2);
        tick();
        check_state("at_0x7c", 32'h7C, 1'b0, 1'b0, 3);
        tick();
        check_state("overrun", 32'h7C, 1'b0, 1'b1, 3);
        tick();
        check_state("overrun_sticky", 32'h7C, 1'b0, 1'b1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
